// File: rtl/portb_arbiter.sv
// Two-master arbiter for the shared data port B: registered ownership with
// round-robin tie-break, bounded burst hold and a read-return pipe matched to RAM latency.
module portb_arbiter #(
  parameter int unsigned BURST     = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] IDLE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        stall_cpu,
  output logic [31:0] addr_b,
  output logic [31:0] data_b_out,
  output logic        we_b,
  input  logic [31:0] data_b_in
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  state_t     r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic       r_rr, w_rr_next;
  logic       w_rd_valid, w_rd_owner;
  logic       w_tail_valid, w_tail_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rr    <= w_rr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rr_next    = r_rr;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (m0_req && m1_req) w_state_next = r_rr ? OWN1 : OWN0;
        else if (m0_req)      w_state_next = OWN0;
        else if (m1_req)      w_state_next = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          w_cnt_next = '0;
          if (m1_req) begin
            w_state_next = OWN1;
            w_rr_next    = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else if (m1_req) begin
          if (r_cnt == CNT_LAST) begin
            w_state_next = OWN1;
            w_cnt_next   = '0;
            w_rr_next    = 1'b1;
          end else if (r_cnt != 4'hF) begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end else begin
          w_cnt_next = '0;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          w_cnt_next = '0;
          if (m0_req) begin
            w_state_next = OWN0;
            w_rr_next    = 1'b0;
          end else begin
            w_state_next = IDLE;
          end
        end else if (m0_req) begin
          if (r_cnt == CNT_LAST) begin
            w_state_next = OWN0;
            w_cnt_next   = '0;
            w_rr_next    = 1'b0;
          end else if (r_cnt != 4'hF) begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end else begin
          w_cnt_next = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Grants come straight off the registered owner so port B never glitches to a non-owner.
  assign m0_gnt    = (r_state == OWN0) & m0_req;
  assign m1_gnt    = (r_state == OWN1) & m1_req;
  assign stall_cpu = m0_req & ~m0_gnt;

  assign addr_b     = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : IDLE_ADDR);
  assign data_b_out = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : 32'h0);
  assign we_b       = (m0_gnt & m0_we) | (m1_gnt & m1_we);

  assign w_rd_valid = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
  assign w_rd_owner = m1_gnt;

  generate
    if (RD_LAT == 0) begin : g_comb
      assign w_tail_valid = w_rd_valid;
      assign w_tail_owner = w_rd_owner;
    end else begin : g_pipe
      logic [RD_LAT-1:0] r_pipe_valid;
      logic [RD_LAT-1:0] r_pipe_owner;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipe_valid <= '0;
          r_pipe_owner <= '0;
        end else begin
          for (int k = RD_LAT - 1; k > 0; k--) begin
            r_pipe_valid[k] <= r_pipe_valid[k-1];
            r_pipe_owner[k] <= r_pipe_owner[k-1];
          end
          r_pipe_valid[0] <= w_rd_valid;
          r_pipe_owner[0] <= w_rd_owner;
        end
      end

      assign w_tail_valid = r_pipe_valid[RD_LAT-1];
      assign w_tail_owner = r_pipe_owner[RD_LAT-1];
    end
  endgenerate

  assign m0_rvalid = w_tail_valid & ~w_tail_owner;
  assign m1_rvalid = w_tail_valid &  w_tail_owner;
  assign m0_rdata  = m0_rvalid ? data_b_in : 32'h0;
  assign m1_rdata  = m1_rvalid ? data_b_in : 32'h0;

endmodule

// File: tb/tb_portb_arbiter.sv
// Bench for portb_arbiter: RD_LAT=1 and RD_LAT=2 instances share master stimulus,
// each with its own RAM; outputs are compared against a cycle-level ownership/read model.
`timescale 1ns/1ps
module tb_portb_arbiter;

  localparam int          BURST = 4;
  localparam logic [31:0] IDLE1 = 32'h0;
  localparam logic [31:0] IDLE2 = 32'h40;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  g0, g1, rv0, rv1, stall, web;
  logic [1:0][31:0] rd0, rd1, addrb, doutb, dinb;

  portb_arbiter #(.BURST(BURST), .RD_LAT(1), .IDLE_ADDR(IDLE1)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(g0[0]), .m0_rdata(rd0[0]), .m0_rvalid(rv0[0]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_gnt(g1[0]), .m1_rdata(rd1[0]), .m1_rvalid(rv1[0]),
    .stall_cpu(stall[0]), .addr_b(addrb[0]), .data_b_out(doutb[0]), .we_b(web[0]),
    .data_b_in(dinb[0])
  );

  portb_arbiter #(.BURST(BURST), .RD_LAT(2), .IDLE_ADDR(IDLE2)) u_dut2 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(g0[1]), .m0_rdata(rd0[1]), .m0_rvalid(rv0[1]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_gnt(g1[1]), .m1_rdata(rd1[1]), .m1_rvalid(rv1[1]),
    .stall_cpu(stall[1]), .addr_b(addrb[1]), .data_b_out(doutb[1]), .we_b(web[1]),
    .data_b_in(dinb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // Per-instance RAMs: 1-cycle and 2-cycle registered read.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] mem_ref [256];
  logic [31:0] q_a, q_b1, q_b2;
  logic        fill;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_val(i);
        mem_b[i] <= init_val(i);
      end
    end else begin
      if (web[0]) mem_a[idx(addrb[0])] <= doutb[0];
      if (web[1]) mem_b[idx(addrb[1])] <= doutb[1];
    end
    q_a  <= mem_a[idx(addrb[0])];
    q_b1 <= mem_b[idx(addrb[1])];
    q_b2 <= q_b1;
  end
  assign dinb[0] = q_a;
  assign dinb[1] = q_b2;

  // Reference model state
  typedef struct {
    int          cyc;
    bit          who;
    logic [31:0] data;
  } rd_t;
  rd_t reads[$];
  int  own;      // 0 none, 1 M0, 2 M1
  int  fav;      // 0 M0 preferred, 1 M1 preferred
  int  streak;   // granted cycles for current owner while the other waits
  int  t;
  int  n_checks, n_errors;
  logic        cur0_req, cur0_we, cur1_req, cur1_we, last_g0, last_g1;
  logic [31:0] cur0_addr, cur0_wdata, cur1_addr, cur1_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; fav = 0; streak = 0;
    reads.delete();
    last_g0 = 1'b0; last_g1 = 1'b0;
  endtask

  task automatic step(input logic r0, input logic [31:0] a0, input logic [31:0] w0, input logic e0,
                      input logic r1, input logic [31:0] a1, input logic [31:0] w1, input logic e1);
    logic        eg0, eg1, ev0, ev1, ewe, mine, theirs;
    logic [31:0] eaddr, edout, edata, idle;
    int          lat, other;
    @(negedge clk);
    m0_req = r0; m0_addr = a0; m0_wdata = w0; m0_we = e0;
    m1_req = r1; m1_addr = a1; m1_wdata = w1; m1_we = e1;
    cur0_req = r0; cur0_addr = a0; cur0_wdata = w0; cur0_we = e0;
    cur1_req = r1; cur1_addr = a1; cur1_wdata = w1; cur1_we = e1;
    #2;
    eg0 = (own == 1) && r0;
    eg1 = (own == 2) && r1;
    for (int k = 0; k < 2; k++) begin
      lat  = k + 1;
      idle = (k == 0) ? IDLE1 : IDLE2;
      eaddr = eg0 ? a0 : (eg1 ? a1 : idle);
      edout = eg0 ? w0 : (eg1 ? w1 : 32'h0);
      ewe   = (eg0 && e0) || (eg1 && e1);
      ev0 = 1'b0; ev1 = 1'b0; edata = 32'h0;
      foreach (reads[j]) begin
        if (reads[j].cyc == t - lat) begin
          ev0 = !reads[j].who; ev1 = reads[j].who; edata = reads[j].data;
        end
      end
      chk($sformatf("c%0d.lat%0d.gnt_stall_we_rv", t, lat),
          {26'h0, g0[k], g1[k], stall[k], web[k], rv0[k], rv1[k]},
          {26'h0, eg0, eg1, r0 & ~eg0, ewe, ev0, ev1});
      chk($sformatf("c%0d.lat%0d.addr_b", t, lat), addrb[k], eaddr);
      chk($sformatf("c%0d.lat%0d.data_b_out", t, lat), doutb[k], edout);
      chk($sformatf("c%0d.lat%0d.m0_rdata", t, lat), rd0[k], ev0 ? edata : 32'h0);
      chk($sformatf("c%0d.lat%0d.m1_rdata", t, lat), rd1[k], ev1 ? edata : 32'h0);
    end
    // Access takes effect in grant order.
    if (eg0 && !e0) reads.push_back('{t, 1'b0, mem_ref[idx(a0)]});
    if (eg0 &&  e0) mem_ref[idx(a0)] = w0;
    if (eg1 && !e1) reads.push_back('{t, 1'b1, mem_ref[idx(a1)]});
    if (eg1 &&  e1) mem_ref[idx(a1)] = w1;
    // Ownership for the next cycle.
    if (own == 0) begin
      streak = 0;
      if (r0 && r1)  own = (fav == 0) ? 1 : 2;
      else if (r0)   own = 1;
      else if (r1)   own = 2;
    end else begin
      mine   = (own == 1) ? r0 : r1;
      theirs = (own == 1) ? r1 : r0;
      other  = 3 - own;
      if (!mine) begin
        streak = 0;
        if (theirs) begin own = other; fav = other - 1; end
        else own = 0;
      end else if (theirs) begin
        streak++;
        if (streak == BURST) begin own = other; fav = other - 1; streak = 0; end
      end else begin
        streak = 0;
      end
    end
    while (reads.size() > 0 && reads[0].cyc < t - 2) void'(reads.pop_front());
    last_g0 = eg0; last_g1 = eg1;
    t++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst.async.gnt_rvalid", {28'h0, g0, rv0} | {28'h0, g1, rv1}, 32'h0);
    chk("rst.async.addr_b1", addrb[0], IDLE1);
    chk("rst.async.addr_b2", addrb[1], IDLE2);
    chk("rst.async.we_b", {30'h0, web}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 32'd16;
      1: return 32'd4;
      2: return 32'd8;
      3: return 32'd65540;
      default: return 32'($urandom_range(0, 255)) << 2;
    endcase
  endfunction

  task automatic rand_run(input int n);
    logic        r0, e0, r1, e1;
    logic [31:0] a0, w0, a1, w1;
    for (int i = 0; i < n; i++) begin
      if (cur0_req && !last_g0) begin
        r0 = cur0_req; a0 = cur0_addr; w0 = cur0_wdata; e0 = cur0_we;
      end else begin
        r0 = ($urandom_range(0, 99) < 60); a0 = pick_addr(); w0 = $urandom; e0 = ($urandom_range(0, 3) == 0);
      end
      if (cur1_req && !last_g1) begin
        r1 = cur1_req; a1 = cur1_addr; w1 = cur1_wdata; e1 = cur1_we;
      end else begin
        r1 = ($urandom_range(0, 99) < 60); a1 = pick_addr(); w1 = $urandom; e1 = ($urandom_range(0, 2) == 0);
      end
      step(r0, a0, w0, e0, r1, a1, w1, e1);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; t = 0;
    fill = 1'b1;
    rst  = 1'b1;
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
    cur0_req = 0; cur0_addr = 0; cur0_wdata = 0; cur0_we = 0;
    cur1_req = 0; cur1_addr = 0; cur1_wdata = 0; cur1_we = 0;
    for (int i = 0; i < 256; i++) mem_ref[i] = init_val(i);
    model_reset();
    #3;
    chk("reset.ctl", {26'h0, g0, g1, stall, web, rv0, rv1}, 32'h0);
    chk("reset.addr_b1", addrb[0], IDLE1);
    chk("reset.addr_b2", addrb[1], IDLE2);
    chk("reset.data_b_out", doutb[0] | doutb[1], 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    fill = 1'b0;

    // M0 alone reads addr 16
    idle_cycles(1);
    step(1, 16, 0, 0, 0, 0, 0, 0);
    step(1, 16, 0, 0, 0, 0, 0, 0);
    idle_cycles(3);

    // Contention from IDLE: M0 burst, M1 burst, M0 burst, then M1 owns and drops
    for (int i = 0; i < 14; i++) step(1, 4, 0, 0, 1, 8, 0, 0);
    step(1, 4, 0, 0, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0, 0, 0);
    idle_cycles(3);

    // M1 writes while M0 is stalled, then M0 reads it back
    step(0, 0, 0, 0, 1, 65540, 32'h1234, 1);
    step(1, 16, 0, 0, 1, 65540, 32'h1234, 1);
    step(1, 16, 0, 0, 0, 0, 0, 0);
    step(1, 16, 0, 0, 0, 0, 0, 0);
    step(1, 65540, 0, 0, 0, 0, 0, 0);
    idle_cycles(3);

    // Reset mid-burst with a read in flight, then contention again
    for (int i = 0; i < 3; i++) step(1, 8, 0, 0, 1, 4, 0, 0);
    async_reset();
    step(1, 8, 0, 0, 1, 4, 0, 0);
    step(1, 8, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 1, 4, 0, 0);
    idle_cycles(3);

    rand_run(800);
    async_reset();
    rand_run(800);
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
